// File: rtl/seg7_bcd_decoder.sv
// Recovers a 4-digit BCD frame from a multiplexed 7-segment display bus.
// Define SEG7_DECODE_ERR_EN to capture illegal patterns as 4'hF and pulse oErr.
module seg7_bcd_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [6:0]  iSeg,
    input  logic [3:0]  iDig,
    input  logic        iReady,
    output logic [15:0] oBCD,
    output logic        oValid,
    output logic        oErr,
    output logic        oOverrun
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);
    localparam logic [7:0] CntPre = 8'(STABLE_CYCLES - 2);

    logic [6:0]  seg_q, seg_prev_q;
    logic [3:0]  dig_q, dig_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] slots_q, slots_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;

    logic        onehot, qualify, capture, legal, load;
    logic [1:0]  idx;
    logic [3:0]  nib;

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (dig_q)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'hF;
        case (seg_q)
            7'b1111110: nib = 4'd0;
            7'b0110000: nib = 4'd1;
            7'b1101101: nib = 4'd2;
            7'b1111001: nib = 4'd3;
            7'b0110011: nib = 4'd4;
            7'b1011011: nib = 4'd5;
            7'b1011111: nib = 4'd6;
            7'b1110000: nib = 4'd7;
            7'b1111111: nib = 4'd8;
            7'b1111011: nib = 4'd9;
            default:    legal = 1'b0;
        endcase
    end

    // Capture fires only on the transition into STABLE_CYCLES-1, so once per dwell.
    always_comb begin
        qualify = (seg_q == seg_prev_q) && (dig_q == dig_prev_q) && onehot && (seg_q != 7'd0);
        capture = qualify && (cnt_q == CntPre);
        if (!qualify) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        load    = (mask_q == 4'b1111);
        slots_d = slots_q;
        mask_d  = load ? 4'b0000 : mask_q;
        err_d   = 1'b0;
        if (capture && legal) begin
            slots_d[{idx, 2'b00} +: 4] = nib;
            mask_d[idx]                = 1'b1;
        end
`ifdef SEG7_DECODE_ERR_EN
        else if (capture) begin
            slots_d[{idx, 2'b00} +: 4] = 4'hF;
            mask_d[idx]                = 1'b1;
            err_d                      = 1'b1;
        end
`endif
        bcd_d     = load ? slots_q : bcd_q;
        valid_d   = load | (valid_q & ~iReady);
        overrun_d = load & valid_q & ~iReady;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            seg_q      <= 7'd0;
            seg_prev_q <= 7'd0;
            dig_q      <= 4'd0;
            dig_prev_q <= 4'd0;
            cnt_q      <= 8'd0;
            slots_q    <= 16'h0000;
            mask_q     <= 4'd0;
            bcd_q      <= 16'h0000;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            seg_q      <= iSeg;
            seg_prev_q <= seg_q;
            dig_q      <= iDig;
            dig_prev_q <= dig_q;
            cnt_q      <= cnt_d;
            slots_q    <= slots_d;
            mask_q     <= mask_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign oBCD     = bcd_q;
    assign oValid   = valid_q;
    assign oErr     = err_q;
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_seg7_bcd_decoder.sv
// Directed bench for seg7_bcd_decoder; accepted frames are checked against a queue.
// Inputs change 2 ns after the rising edge; the monitor samples on the falling edge.
module tb_seg7_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  iSeg;
    logic [3:0]  iDig;
    logic        iReady;
    logic [15:0] oBCD;
    logic        oValid, oErr, oOverrun;

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int n_ovr = 0;
    int n_vcyc = 0;
    int base_err, base_ovr, base_vcyc;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    seg7_bcd_decoder #(.STABLE_CYCLES(4)) u_dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iSeg    (iSeg),
        .iDig    (iDig),
        .iReady  (iReady),
        .oBCD    (oBCD),
        .oValid  (oValid),
        .oErr    (oErr),
        .oOverrun(oOverrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic drive(input logic [3:0] dig, input logic [6:0] seg, input int edges);
        iDig = dig;
        iSeg = seg;
        repeat (edges) @(posedge clk);
        #2;
    endtask

    task automatic put(input int n, input logic [3:0] v, input int edges);
        drive(4'(1 << n), seg_of(v), edges);
    endtask

    task automatic idle(input int edges);
        drive(4'b0001, 7'b0000000, edges);
    endtask

    task automatic frame(input logic [15:0] f);
        put(3, f[15:12], 6);
        put(2, f[11:8], 6);
        put(1, f[7:4], 6);
        put(0, f[3:0], 6);
    endtask

    // Scoreboard: every accepted frame must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oErr) n_err++;
            if (oOverrun) n_ovr++;
            if (oValid) n_vcyc++;
            if (oValid && iReady) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("frame_value", 32'(oBCD), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        iSeg   = 7'd0;
        iDig   = 4'd0;
        iReady = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_bcd", 32'(oBCD), 32'h0);
        check("rst_valid", 32'(oValid), 32'h0);
        check("rst_err", 32'(oErr), 32'h0);
        check("rst_ovr", 32'(oOverrun), 32'h0);
        rst_n = 1'b1;
        idle(3);

        // Basic frame, consumer always ready
        base_vcyc = n_vcyc;
        exp_q.push_back(16'h1984);
        frame(16'h1984);
        idle(6);
        check("basic_valid_cycles", 32'(n_vcyc - base_vcyc), 32'd1);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Exactly STABLE_CYCLES identical samples capture
        exp_q.push_back(16'h2467);
        put(3, 4'd2, 6);
        put(2, 4'd4, 6);
        put(1, 4'd6, 6);
        put(0, 4'd7, 4);
        idle(6);
        check("dwell4_drained", 32'(exp_q.size()), 32'd0);

        // One sample short does not overwrite slot 0
        exp_q.push_back(16'h1115);
        put(0, 4'd5, 6);
        idle(1);
        put(0, 4'd7, 3);
        idle(1);
        put(3, 4'd1, 6);
        put(2, 4'd1, 6);
        put(1, 4'd1, 6);
        idle(6);
        check("dwell3_drained", 32'(exp_q.size()), 32'd0);

        // Overrun: two frames with consumer stalled
        iReady = 1'b0;
        base_ovr = n_ovr;
        frame(16'h1234);
        idle(4);
        check("stall_valid1", 32'(oValid), 32'd1);
        check("stall_bcd1", 32'(oBCD), 32'h1234);
        check("stall_no_ovr", 32'(n_ovr - base_ovr), 32'd0);
        frame(16'h5678);
        idle(4);
        check("ovr_valid", 32'(oValid), 32'd1);
        check("ovr_bcd", 32'(oBCD), 32'h5678);
        check("ovr_pulses", 32'(n_ovr - base_ovr), 32'd1);
        exp_q.push_back(16'h5678);
        iReady = 1'b1;
        idle(3);
        check("ovr_drained", 32'(exp_q.size()), 32'd0);
        check("ovr_valid_clear", 32'(oValid), 32'd0);

        // Illegal pattern on digit 2
        base_err = n_err;
`ifdef SEG7_DECODE_ERR_EN
        exp_q.push_back(16'h0F00);
`endif
        put(3, 4'd0, 6);
        drive(4'b0100, 7'b1001001, 6);
        put(1, 4'd0, 6);
        put(0, 4'd0, 6);
        idle(6);
`ifdef SEG7_DECODE_ERR_EN
        check("illegal_err_pulses", 32'(n_err - base_err), 32'd1);
`else
        check("illegal_err_pulses", 32'(n_err - base_err), 32'd0);
        check("illegal_no_frame", 32'(oValid), 32'd0);
`endif
        check("illegal_drained", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        idle(3);

        // Non-one-hot enables and blank segments never capture
        base_err = n_err;
        drive(4'b0011, seg_of(4'd8), 10);
        idle(10);
        put(3, 4'd9, 6);
        put(2, 4'd9, 6);
        put(1, 4'd9, 6);
        idle(5);
        check("noncap_valid", 32'(oValid), 32'd0);
        check("noncap_err", 32'(n_err - base_err), 32'd0);
        exp_q.push_back(16'h9993);
        put(0, 4'd3, 6);
        idle(5);
        check("noncap_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame discards the partial slots
        put(3, 4'd7, 6);
        put(2, 4'd7, 6);
        put(1, 4'd7, 6);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(oBCD), 32'h0);
        check("midrst_valid", 32'(oValid), 32'd0);
        #2;
        rst_n = 1'b1;
        idle(2);
        put(0, 4'd8, 6);
        idle(6);
        check("postrst_valid", 32'(oValid), 32'd0);
        check("postrst_bcd", 32'(oBCD), 32'h0);
        check("postrst_err", 32'(oErr), 32'd0);
        check("postrst_ovr", 32'(oOverrun), 32'd0);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
